fetch_queue_unit: RTL and testbench
===================================

Name: fetch_queue_unit

Overview:
- Parametrised instruction-fetch stage: next-PC selection, instruction-memory requests and a DEPTH-entry fetch queue between fetch and decode.
- Successor to the single-register fetch stage. Adds a synchronous 1-cycle-latency instruction memory, a valid/ready handshake to decode, wrong-path flush on redirect, jalr LSB masking and misaligned-target detection.
- Sits between the E-stage redirect sources and the D-stage pipeline register.

Parameters:
WIDTH, 32, data/address width in bits
DEPTH, 4, fetch queue entries (power of 2, at least 2)
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
pc_src_i  in  2  00 sequential, 01 branch/jal (pc_target_i), 10 jalr (alu_result_i), 11 reserved = no redirect
pc_target_i  in  WIDTH  PC+imm target from E
alu_result_i  in  WIDTH  jalr target from E
imem_req_o  out  1  read request this cycle
imem_addr_o  out  WIDTH  read address (word aligned)
imem_rdata_i  in  WIDTH  read data, valid exactly one cycle after imem_req_o
instr_o  out  WIDTH  queue-head instruction
pc_o  out  WIDTH  queue-head PC
pc_plus4_o  out  WIDTH  queue-head PC+4
valid_o  out  1  queue head valid
ready_i  in  1  decode accepts head (0 = stall)
misalign_o  out  1  sticky: current redirect target not word aligned

Behaviour:
- Reset (async, immediate):
  - fetch PC register = RESET_PC; queue empty; inflight = 0; misalign_o = 0.
  - valid_o = 0, imem_req_o = 0; instr_o/pc_o/pc_plus4_o = 0.
  - Release mid-operation: all prior state discarded; first request at RESET_PC in the first cycle after rst falls.
- Redirect:
  - redirect = pc_src_i is 01 or 10.
  - Target: pc_target_i for 01; alu_result_i with bit 0 forced to 0 for 10.
- Request issue (combinational):
  - imem_req_o = !redirect & !misalign_o & (count + inflight < DEPTH).
  - imem_addr_o = fetch PC. On each request, fetch PC += 4 (modulo 2^WIDTH; wraps from 0xFFFFFFFC to 0).
- Response handling:
  - inflight is a 1-bit register = request issued last cycle and not killed.
  - On a live response, push {pc, pc+4, imem_rdata_i} at that cycle's edge.
  - The credit rule guarantees the queue never overflows; push on a full queue is an assertion failure.
- Handshake:
  - valid_o = count != 0; head pops when valid_o & ready_i.
  - Head fields are stable while valid_o & !ready_i.
  - Push and pop in the same cycle: count unchanged.
- Redirect cycle (priority over everything):
  - Queue cleared; inflight killed, so the next-cycle response is dropped.
  - fetch PC <= target; no request this cycle.
  - A pop in the same cycle is allowed (decode flushes it itself).
  - misalign_o <= (target[1:0] != 0). While misalign_o is set, no requests are issued until the next redirect.
- Latency and throughput:
  - Redirect in cycle N: request at target in N+1, data in N+2, valid_o high in N+3.
  - Steady state with ready_i = 1: 1 instruction per cycle once the pipeline is full.
- Stall: with ready_i = 0, the queue fills to DEPTH and then requests stop. No instruction is lost or duplicated.
- Reserved pc_src_i = 11: behaves as 00; an assertion flags it.

Decomposition:
- Shared package fetch_pkg:
  - enum pc_src_e {PC_SEQ = 2'b00, PC_BRANCH = 2'b01, PC_JALR = 2'b10}.
  - struct fetch_entry_t {pc, pc_plus4, instr}.
  - constant INSTR_BYTES = 4.
- One natural sub-module: fetch_fifo, a generic DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count and async reset.
- PC and credit logic stay in fetch_queue_unit.

Test Plan:
- Reset release, RESET_PC = 0x0, ready_i = 1, memory returns addr|0xA000 -> imem_addr_o issues 0x0, 0x4, 0x8 on consecutive cycles; valid_o first high 2 cycles after release; instr_o 0xA000, 0xA004, 0xA008 in order, one per cycle.
- Stall: ready_i = 0 for 10 cycles, DEPTH = 4 -> exactly 4 requests issued, count = 4, imem_req_o = 0 thereafter. On ready_i = 1, instructions pop in order with no gap or duplicate.
- Branch redirect pc_src_i = 01, pc_target_i = 0x100, while queue holds 3 entries and 1 inflight -> all 4 dropped; next request address 0x100; valid_o rises 3 cycles after the redirect with pc_o = 0x100 and pc_plus4_o = 0x104.
- jalr pc_src_i = 10, alu_result_i = 0x201 -> fetch from 0x200, misalign_o = 0. alu_result_i = 0x202 -> misalign_o = 1, no requests until a subsequent redirect to 0x300 clears it and fetches 0x300.
- Wrap: redirect to 0xFFFFFFFC -> pc_o = 0xFFFFFFFC with pc_plus4_o = 0x0, then next pc_o = 0x0.
- Async reset asserted mid-stream with queue partly full -> valid_o and imem_req_o drop to 0 the same cycle; after release, fetch restarts at RESET_PC with no stale entry emitted.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage and its fetch queue.
// WIDTH of fetch_queue_unit must equal XLEN because the queue entry is a fixed-width struct.
package fetch_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JALR   = 2'b10
  } pc_src_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetch entries with flush and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  fetch_entry_t i_data,
  input  logic         i_pop,
  output fetch_entry_t o_data,
  output logic [CW-1:0] o_count
);

  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_do_pop;

  assign w_do_pop = i_pop && (r_count != '0);
  assign o_data   = r_mem[r_rptr];
  assign o_count  = r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop) r_rptr <= r_rptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wptr] <= i_data;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_flush && (r_count == FullCount)));

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch stage: next-PC selection, 1-cycle-latency imem requests under a credit
// limit, and a fetch queue toward decode with wrong-path flush on redirect.
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       pc_src_i,
  input  logic [WIDTH-1:0] pc_target_i,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             imem_req_o,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic [WIDTH-1:0] imem_rdata_i,
  output logic [WIDTH-1:0] instr_o,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus4_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             misalign_o
);

  localparam int unsigned      CW       = $clog2(DEPTH) + 1;
  localparam logic [CW:0]      DepthW   = (CW + 1)'(DEPTH);
  localparam logic [WIDTH-1:0] PcStep   = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] JalrMask = ~WIDTH'(1);

  logic [WIDTH-1:0] r_fetch_pc;
  logic [WIDTH-1:0] r_resp_pc;
  logic             r_inflight;
  logic             r_misalign;

  logic             w_redirect;
  logic [WIDTH-1:0] w_target;
  logic [CW-1:0]    w_count;
  logic [CW:0]      w_used;
  logic             w_req;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  fetch_entry_t     w_push_entry;
  fetch_entry_t     w_head;

  assign w_redirect = (pc_src_i == PC_BRANCH) || (pc_src_i == PC_JALR);
  assign w_target   = (pc_src_i == PC_JALR) ? (alu_result_i & JalrMask) : pc_target_i;

  // Queue slots already claimed, counting the response still in flight.
  assign w_used = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_req  = !rst && !w_redirect && !r_misalign && (w_used < DepthW);

  // A redirect in the response cycle drops that response along with the queue.
  assign w_push  = r_inflight && !w_redirect;
  assign w_valid = (w_count != '0);
  assign w_pop   = w_valid && ready_i;

  assign w_push_entry.pc       = r_resp_pc;
  assign w_push_entry.pc_plus4 = r_resp_pc + PcStep;
  assign w_push_entry.instr    = imem_rdata_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= '0;
      r_inflight <= 1'b0;
      r_misalign <= 1'b0;
    end else begin
      r_inflight <= w_req;
      if (w_req) r_resp_pc <= r_fetch_pc;
      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_misalign <= (w_target[1:0] != 2'b00);
      end else if (w_req) begin
        r_fetch_pc <= r_fetch_pc + PcStep;
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (w_redirect),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  assign imem_req_o  = w_req;
  assign imem_addr_o = r_fetch_pc;
  assign valid_o     = w_valid;
  assign misalign_o  = r_misalign;
  assign instr_o     = w_valid ? w_head.instr    : '0;
  assign pc_o        = w_valid ? w_head.pc       : '0;
  assign pc_plus4_o  = w_valid ? w_head.pc_plus4 : '0;

  a_no_reserved_src : assert property (@(posedge clk) disable iff (rst) pc_src_i != 2'b11);

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit; the memory model answers each read with addr | 0xA000.
module tb_fetch_queue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  pc_src;
  logic [31:0] pc_target;
  logic [31:0] alu_result;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_rdata;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;
  logic        valid_o;
  logic        ready;
  logic        misalign_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  fetch_queue_unit #(
    .WIDTH    (32),
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pc_src_i     (pc_src),
    .pc_target_i  (pc_target),
    .alu_result_i (alu_result),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_rdata_i (imem_rdata),
    .instr_o      (instr_o),
    .pc_o         (pc_o),
    .pc_plus4_o   (pc_plus4_o),
    .valid_o      (valid_o),
    .ready_i      (ready),
    .misalign_o   (misalign_o)
  );

  always @(posedge clk) begin
    if (imem_req_o) imem_rdata <= imem_addr_o | 32'hA000;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int nreq;
    rst = 1'b1; pc_src = 2'b00; pc_target = '0; alu_result = '0; ready = 1'b1;
    imem_rdata = '0;
    step(); step();
    check_eq("rst_valid", valid_o, 0);
    check_eq("rst_req", imem_req_o, 0);
    check_eq("rst_misalign", misalign_o, 0);
    check_eq("rst_pc", pc_o, 0);
    check_eq("rst_instr", instr_o, 0);

    // Reset release, streaming with ready high
    rst = 1'b0; #1;
    check_eq("t1_req0", imem_req_o, 1);
    check_eq("t1_addr0", imem_addr_o, 32'h0);
    step();
    check_eq("t1_addr1", imem_addr_o, 32'h4);
    check_eq("t1_valid_lo", valid_o, 0);
    step();
    check_eq("t1_valid_hi", valid_o, 1);
    check_eq("t1_addr2", imem_addr_o, 32'h8);
    check_eq("t1_instr0", instr_o, 32'hA000);
    check_eq("t1_pc0", pc_o, 32'h0);
    check_eq("t1_pc4_0", pc_plus4_o, 32'h4);
    step();
    check_eq("t1_instr1", instr_o, 32'hA004);
    step();
    check_eq("t1_instr2", instr_o, 32'hA008);

    // Stall from reset: queue fills to four and requests stop
    rst = 1'b1; ready = 1'b0; step();
    rst = 1'b0; #1;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req_o) nreq++;
      step();
    end
    check_eq("stall_nreq", nreq, 4);
    check_eq("stall_req_off", imem_req_o, 0);
    check_eq("stall_valid", valid_o, 1);
    check_eq("stall_head", pc_o, 32'h0);
    ready = 1'b1; #1;
    for (int k = 0; k < 6; k++) begin
      check_eq("drain_valid", valid_o, 1);
      check_eq("drain_pc", pc_o, 32'(4 * k));
      check_eq("drain_instr", instr_o, 32'hA000 + 32'(4 * k));
      step();
    end

    // Branch redirect with three queued entries and one inflight
    rst = 1'b1; ready = 1'b0; step();
    rst = 1'b0; #1;
    step(); step(); step(); step();
    check_eq("br_pre_valid", valid_o, 1);
    pc_src = 2'b01; pc_target = 32'h100; #1;
    check_eq("br_req_blocked", imem_req_o, 0);
    step();
    pc_src = 2'b00; #1;
    check_eq("br_flushed", valid_o, 0);
    check_eq("br_req", imem_req_o, 1);
    check_eq("br_addr", imem_addr_o, 32'h100);
    ready = 1'b1;
    step();
    check_eq("br_drop_inflight", valid_o, 0);
    check_eq("br_addr1", imem_addr_o, 32'h104);
    step();
    check_eq("br_valid", valid_o, 1);
    check_eq("br_pc", pc_o, 32'h100);
    check_eq("br_pc4", pc_plus4_o, 32'h104);
    check_eq("br_instr", instr_o, 32'hA100);
    step();
    check_eq("br_pc_next", pc_o, 32'h104);

    // jalr: LSB masked, then misaligned target blocks fetch until next redirect
    pc_src = 2'b10; alu_result = 32'h201; #1;
    step();
    pc_src = 2'b00; #1;
    check_eq("jalr_addr", imem_addr_o, 32'h200);
    check_eq("jalr_req", imem_req_o, 1);
    check_eq("jalr_misalign", misalign_o, 0);
    step(); step();
    check_eq("jalr_pc", pc_o, 32'h200);
    pc_src = 2'b10; alu_result = 32'h202; #1;
    step();
    pc_src = 2'b00; #1;
    check_eq("mis_set", misalign_o, 1);
    check_eq("mis_req", imem_req_o, 0);
    step(); step();
    check_eq("mis_req_held", imem_req_o, 0);
    check_eq("mis_valid", valid_o, 0);
    pc_src = 2'b01; pc_target = 32'h300; #1;
    step();
    pc_src = 2'b00; #1;
    check_eq("mis_clear", misalign_o, 0);
    check_eq("mis_req_resume", imem_req_o, 1);
    check_eq("mis_addr", imem_addr_o, 32'h300);
    step(); step();
    check_eq("mis_pc", pc_o, 32'h300);
    check_eq("mis_instr", instr_o, 32'hA300);

    // PC wrap at the top of the address space
    pc_src = 2'b01; pc_target = 32'hFFFF_FFFC; #1;
    step();
    pc_src = 2'b00; #1;
    check_eq("wrap_addr0", imem_addr_o, 32'hFFFF_FFFC);
    step();
    check_eq("wrap_addr1", imem_addr_o, 32'h0);
    step();
    check_eq("wrap_pc", pc_o, 32'hFFFF_FFFC);
    check_eq("wrap_pc4", pc_plus4_o, 32'h0);
    step();
    check_eq("wrap_pc_next", pc_o, 32'h0);
    check_eq("wrap_pc4_next", pc_plus4_o, 32'h4);

    // Async reset mid-stream with a partly full queue
    ready = 1'b0;
    step(); step();
    check_eq("ar_pre_valid", valid_o, 1);
    #2;
    rst = 1'b1; #1;
    check_eq("ar_valid", valid_o, 0);
    check_eq("ar_req", imem_req_o, 0);
    step();
    rst = 1'b0; ready = 1'b1; #1;
    check_eq("ar_req_restart", imem_req_o, 1);
    check_eq("ar_addr_restart", imem_addr_o, 32'h0);
    check_eq("ar_no_stale", valid_o, 0);
    step();
    check_eq("ar_no_stale2", valid_o, 0);
    step();
    check_eq("ar_valid_back", valid_o, 1);
    check_eq("ar_pc", pc_o, 32'h0);
    check_eq("ar_instr", instr_o, 32'hA000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
